// File: rtl/riscv_pkg.sv
// Shared pipeline types for the RV64I core.
// Holds load/store sizes and the LSU state encoding.
package riscv_pkg;

  typedef enum logic [1:0] {
    LSU_B = 2'd0,
    LSU_H = 2'd1,
    LSU_W = 2'd2,
    LSU_D = 2'd3
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/riscv_lsu_align.sv
// Byte-lane steering for the LSU: enables, store
// replication and load extraction/extension.
module riscv_lsu_align
  import riscv_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [2:0]  off,
  input  logic [63:0] wdata_i,
  input  logic [63:0] rdata_i,
  output logic [7:0]  be_o,
  output logic [63:0] wdata_o,
  output logic [63:0] rdata_o
);

  logic [7:0]  be_base;
  logic [63:0] sh;

  // Lane enables, replicated store data and extended load data
  always_comb begin
    be_base = 8'hFF;
    wdata_o = wdata_i;
    rdata_o = '0;
    sh      = rdata_i >> {off, 3'b000};
    unique case (size)
      LSU_B: begin
        be_base = 8'h01;
        wdata_o = {8{wdata_i[7:0]}};
        rdata_o = {{56{sh[7] & ~uns}}, sh[7:0]};
      end
      LSU_H: begin
        be_base = 8'h03;
        wdata_o = {4{wdata_i[15:0]}};
        rdata_o = {{48{sh[15] & ~uns}}, sh[15:0]};
      end
      LSU_W: begin
        be_base = 8'h0F;
        wdata_o = {2{wdata_i[31:0]}};
        rdata_o = {{32{sh[31] & ~uns}}, sh[31:0]};
      end
      default: begin
        be_base = 8'hFF;
        wdata_o = wdata_i;
        rdata_o = sh;
      end
    endcase
    be_o = be_base << off;
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: MEM stage to req/gnt/rvalid bus.
// FSM plus registered bus and completion outputs.
module riscv_lsu
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sft_rst,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [1:0]            core_size,
  input  logic                  core_unsigned,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic [DATA_WIDTH-1:0] core_rdata,
  output logic                  core_done,
  output logic                  misalign,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  lsu_state_e state_q, state_d;
  logic [1:0] size_q, size_d;
  logic uns_q, uns_d;
  logic [2:0] off_q, off_d;
  logic mem_req_q, mem_req_d;
  logic mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [7:0] mem_be_q, mem_be_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] core_rdata_q, core_rdata_d;
  logic core_done_q, core_done_d;
  logic misalign_q, misalign_d;

  logic [1:0]  a_size;
  logic        a_uns;
  logic [2:0]  a_off;
  logic [7:0]  a_be;
  logic [63:0] a_wdata;
  logic [63:0] a_rdata;
  logic [2:0]  mask;
  logic        mis;

  // In IDLE steer from the core inputs, later from the latched access
  always_comb begin
    a_size = (state_q == IDLE) ? core_size : size_q;
    a_uns  = (state_q == IDLE) ? core_unsigned : uns_q;
    a_off  = (state_q == IDLE) ? core_addr[2:0] : off_q;
  end

  riscv_lsu_align u_align (
    .size    (a_size),
    .uns     (a_uns),
    .off     (a_off),
    .wdata_i (core_wdata),
    .rdata_i (mem_rdata),
    .be_o    (a_be),
    .wdata_o (a_wdata),
    .rdata_o (a_rdata)
  );

  // Misaligned when low address bits fall inside the access size
  always_comb begin
    unique case (core_size)
      2'd0:    mask = 3'b000;
      2'd1:    mask = 3'b001;
      2'd2:    mask = 3'b011;
      default: mask = 3'b111;
    endcase
    mis = |(core_addr[2:0] & mask);
  end

  // Next-state and output register updates
  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    uns_d        = uns_q;
    off_d        = off_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    core_rdata_d = core_rdata_q;
    core_done_d  = 1'b0;
    misalign_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (core_req) begin
          size_d = core_size;
          uns_d  = core_unsigned;
          off_d  = core_addr[2:0];
          if (mis) begin
            state_d      = DONE;
            core_done_d  = 1'b1;
            misalign_d   = 1'b1;
            core_rdata_d = '0;
          end else begin
            state_d     = REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = core_we;
            mem_addr_d  = {core_addr[ADDR_WIDTH-1:3], 3'b000};
            mem_be_d    = a_be;
            mem_wdata_d = a_wdata;
          end
        end
      end
      REQ: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (mem_rvalid) begin
          core_rdata_d = mem_we_q ? '0 : a_rdata;
          core_done_d  = 1'b1;
          state_d      = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with async and sync reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      size_q       <= '0;
      uns_q        <= 1'b0;
      off_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      core_rdata_q <= '0;
      core_done_q  <= 1'b0;
      misalign_q   <= 1'b0;
    end else if (sft_rst) begin
      state_q      <= IDLE;
      size_q       <= '0;
      uns_q        <= 1'b0;
      off_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      core_rdata_q <= '0;
      core_done_q  <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      off_q        <= off_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      core_rdata_q <= core_rdata_d;
      core_done_q  <= core_done_d;
      misalign_q   <= misalign_d;
    end
  end

  assign core_rdata = core_rdata_q;
  assign core_done  = core_done_q;
  assign misalign   = misalign_q;
  assign stall      = core_req & ~core_done_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
